alu_issue_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the 64-bit ALU. Accepts one decoded instruction per handshake and resolves operand forwarding from EX/MEM and MEM/WB.
- Registers ALU operands a/b and the 4-bit ALU operation code, and presents them on a valid/ready interface.
- While stalled it snoops late writebacks into the held register operands, so the ALU never consumes stale data.

---
 rtl/alu_issue_stage_pkg.sv | 43 ++++
 rtl/alu_issue_stage_fwd_mux.sv | 32 +++
 rtl/alu_issue_stage.sv | 115 +++++++++++
 tb/tb_alu_issue_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage and the downstream ALU:
// ALU operation codes, ctrl_aluop encodings, stage state and the ALUOp decoder.
package alu_issue_stage_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  localparam logic [1:0] CTRL_MEM    = 2'b00;
  localparam logic [1:0] CTRL_BRANCH = 2'b01;
  localparam logic [1:0] CTRL_RTYPE  = 2'b10;
  localparam logic [1:0] CTRL_ITYPE  = 2'b11;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
  } aluop_dec_t;

  function automatic aluop_dec_t decode_aluop(input logic [1:0] ctrl,
                                              input logic [2:0] funct3,
                                              input logic       funct7_5);
    aluop_dec_t d;
    d = '{op: ALUOP_ADD, illegal: 1'b0};
    case (ctrl)
      CTRL_MEM:    d.op = ALUOP_ADD;
      CTRL_BRANCH: d.op = ALUOP_SUB;
      default: begin
        case (funct3)
          3'b000:  d.op = (ctrl == CTRL_RTYPE && funct7_5) ? ALUOP_SUB : ALUOP_ADD;
          3'b111:  d.op = ALUOP_AND;
          3'b110:  d.op = ALUOP_OR;
          default: d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand bypass select: EX/MEM beats MEM/WB beats the supplied default data;
// register x0 is never bypassed.
module alu_issue_stage_fwd_mux
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_wr_en,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_wr_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  logic nonzero;
  assign nonzero = (addr != '0);

  always_comb begin
    // NOTE: default assignment first so every path drives data and no latch is inferred.
    data = rf_data;
    if (exm_wr_en && nonzero && exm_rd == addr)
      data = exm_result;
    else if (wb_wr_en && nonzero && wb_rd == addr)
      data = wb_result;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register stage ahead of the ALU: forwards operands at capture, decodes
// ALUOp, and keeps refreshing held operands from late writebacks while stalled.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [RA_W-1:0]  rs1_addr,
  input  logic [RA_W-1:0]  rs2_addr,
  input  logic [RA_W-1:0]  rd_addr,
  input  logic             alu_src,
  input  logic [1:0]       ctrl_aluop,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             exm_wr_en,
  input  logic             wb_wr_en,
  input  logic [RA_W-1:0]  exm_rd,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  exm_result,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [3:0]       ALUOp,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t          state;
  logic [RA_W-1:0] held_rs1;
  logic [RA_W-1:0] held_rs2;
  logic            held_alu_src;
  logic [XLEN-1:0] cap_a, cap_rs2, snoop_a, snoop_b;
  logic            capture, held;
  aluop_dec_t      dec;

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready;
  assign held      = out_valid && !out_ready;
  assign dec       = decode_aluop(ctrl_aluop, funct3, funct7_5);

  alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr(rs1_addr), .rf_data(rs1_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .data(cap_a));

  alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr(rs2_addr), .rf_data(rs2_data),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .data(cap_rs2));

  // Snoop muxes default to the current operand, so a miss leaves it unchanged.
  alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_snoop_a (
    .addr(held_rs1), .rf_data(a),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .data(snoop_a));

  alu_issue_stage_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_snoop_b (
    .addr(held_rs2), .rf_data(b),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .data(snoop_b));

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      a            <= '0;
      b            <= '0;
      ALUOp        <= ALUOP_AND;
      out_rd       <= '0;
      out_illegal  <= 1'b0;
      stall_cnt    <= '0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_alu_src <= 1'b0;
    end else begin
      if (held && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        state <= ST_EMPTY;
      end else if (capture) begin
        state        <= ST_FULL;
        a            <= cap_a;
        b            <= alu_src ? imm : cap_rs2;
        ALUOp        <= dec.op;
        out_illegal  <= dec.illegal;
        out_rd       <= rd_addr;
        held_rs1     <= rs1_addr;
        held_rs2     <= rs2_addr;
        held_alu_src <= alu_src;
      end else if (out_valid && out_ready) begin
        state <= ST_EMPTY;
      end else if (held) begin
        a <= snoop_a;
        if (!held_alu_src)
          b <= snoop_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, alu_src, funct7_5;
  logic [63:0] rs1_data, rs2_data, imm, exm_result, wb_result, a, b;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exm_rd, wb_rd, out_rd;
  logic [1:0]  ctrl_aluop;
  logic [2:0]  funct3;
  logic        exm_wr_en, wb_wr_en, flush, out_valid, out_ready, out_illegal;
  logic [3:0]  ALUOp;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_src(alu_src), .ctrl_aluop(ctrl_aluop), .funct3(funct3), .funct7_5(funct7_5),
    .exm_wr_en(exm_wr_en), .wb_wr_en(wb_wr_en), .exm_rd(exm_rd), .wb_rd(wb_rd),
    .exm_result(exm_result), .wb_result(wb_result), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .ALUOp(ALUOp),
    .out_rd(out_rd), .out_illegal(out_illegal), .stall_cnt(stall_cnt));

  // Reference model: the instruction currently presented to the ALU.
  logic        m_v, m_clean, m_ill, m_src;
  logic [63:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_r1, m_r2;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fwd(input logic [4:0] addr, input logic [63:0] dflt);
    if (addr == 0) return dflt;
    if (exm_wr_en && exm_rd == addr) return exm_result;
    if (wb_wr_en && wb_rd == addr) return wb_result;
    return dflt;
  endfunction

  // Returns {illegal, ALUOp} from the instruction fields.
  function automatic logic [4:0] expect_op();
    if (ctrl_aluop == 2'b00) return {1'b0, 4'b0010};
    if (ctrl_aluop == 2'b01) return {1'b0, 4'b0110};
    if (funct3 == 3'b111) return {1'b0, 4'b0000};
    if (funct3 == 3'b110) return {1'b0, 4'b0001};
    if (funct3 == 3'b000)
      return (ctrl_aluop == 2'b10 && funct7_5) ? {1'b0, 4'b0110} : {1'b0, 4'b0010};
    return {1'b1, 4'b0010};
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_v = 0; m_clean = 1; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_ill = 0; m_cnt = 0;
    end else begin
      if (m_v && !out_ready && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) m_v = 0;
      else if (in_valid && (!m_v || out_ready)) begin
        m_v = 1; m_clean = 0;
        m_a = fwd(rs1_addr, rs1_data);
        m_b = alu_src ? imm : fwd(rs2_addr, rs2_data);
        {m_ill, m_op} = expect_op();
        m_rd = rd_addr; m_r1 = rs1_addr; m_r2 = rs2_addr; m_src = alu_src;
      end else if (m_v && out_ready) m_v = 0;
      else if (m_v) begin
        m_a = fwd(m_r1, m_a);
        if (!m_src) m_b = fwd(m_r2, m_b);
      end
    end
  endtask

  task automatic step();
    #1 check("in_ready", in_ready, !m_v || out_ready);
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, m_v);
    check("stall_cnt", stall_cnt, m_cnt);
    if (m_v || m_clean) begin
      check("a", a, m_a);
      check("b", b, m_b);
      check("ALUOp", ALUOp, m_op);
      check("out_rd", out_rd, m_rd);
      check("out_illegal", out_illegal, m_ill);
    end
  endtask

  task automatic idle();
    rst_n = 1; in_valid = 0; out_ready = 1; flush = 0; alu_src = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    ctrl_aluop = 2'b10; funct3 = 0; funct7_5 = 0;
    exm_wr_en = 0; wb_wr_en = 0; exm_rd = 0; wb_rd = 0; exm_result = 0; wb_result = 0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); step(); rst_n = 1;
  endtask

  initial begin
    int vcount;
    do_reset();
    check("reset_valid", out_valid, 1'b0);

    // R-type SUB, no bypass.
    in_valid = 1; ctrl_aluop = 2'b10; funct3 = 0; funct7_5 = 1;
    rs1_addr = 1; rs2_addr = 2; rd_addr = 7; rs1_data = 64'h10; rs2_data = 64'h3;
    step();
    check("sub_a", a, 64'h10); check("sub_b", b, 64'h3); check("sub_op", ALUOp, 4'b0110);

    // EX/MEM wins over MEM/WB; x0 is not forwarded.
    funct7_5 = 0; rs1_addr = 5; rs1_data = 64'h55;
    exm_wr_en = 1; wb_wr_en = 1; exm_rd = 5; wb_rd = 5; exm_result = 64'hAA; wb_result = 64'hBB;
    step();
    check("fwd_exm", a, 64'hAA);
    rs1_addr = 0; exm_rd = 0; wb_rd = 0;
    step();
    check("fwd_x0", a, 64'h55);

    // Hold for 3 cycles with a writeback snoop on the second.
    idle(); in_valid = 1; rs1_addr = 1; rs2_addr = 3; rs1_data = 64'h1; rs2_data = 64'h2;
    step();
    in_valid = 0; out_ready = 0;
    step();
    wb_wr_en = 1; wb_rd = 3; wb_result = 64'h77;
    step();
    wb_wr_en = 0;
    step();
    check("snoop_b", b, 64'h77); check("stall3", stall_cnt, 32'd3);

    // Four back-to-back instructions at full throughput.
    idle(); vcount = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; rd_addr = 5'(i + 1); rs1_data = 64'(i);
      step();
      if (out_valid) vcount++;
    end
    check("b2b_valid", vcount, 4);
    in_valid = 0; step();

    // Illegal funct3 and I-type ignoring funct7_5.
    in_valid = 1; ctrl_aluop = 2'b10; funct3 = 3'b001;
    step();
    check("ill_op", ALUOp, 4'b0010); check("ill_flag", out_illegal, 1'b1);
    ctrl_aluop = 2'b11; funct3 = 3'b000; funct7_5 = 1;
    step();
    check("itype_op", ALUOp, 4'b0010);

    // Flush while FULL with a new instruction offered.
    out_ready = 0; flush = 1; in_valid = 1;
    step();
    check("flush_valid", out_valid, 1'b0);

    // Reset in the middle of a hold.
    idle(); in_valid = 1; rs1_addr = 2; rs1_data = 64'h99; imm = 64'h5; alu_src = 1;
    step();
    in_valid = 0; out_ready = 0; step(); step();
    rst_n = 0; step();
    check("rst_a", a, 64'h0); check("rst_cnt", stall_cnt, 32'h0);
    check("rst_valid", out_valid, 1'b0);
    rst_n = 1;

    // Randomized traffic with a small register space to provoke bypasses.
    for (int n = 0; n < 2000; n++) begin
      rst_n      = ($urandom_range(99) != 0);
      in_valid   = $urandom_range(3) != 0;
      out_ready  = $urandom_range(9) < 6;
      flush      = $urandom_range(19) == 0;
      alu_src    = $urandom_range(1);
      rs1_addr   = 5'($urandom_range(3));
      rs2_addr   = 5'($urandom_range(3));
      rd_addr    = 5'($urandom);
      exm_rd     = 5'($urandom_range(3));
      wb_rd      = 5'($urandom_range(3));
      exm_wr_en  = $urandom_range(1);
      wb_wr_en   = $urandom_range(1);
      rs1_data   = {$urandom, $urandom};
      rs2_data   = {$urandom, $urandom};
      imm        = {$urandom, $urandom};
      exm_result = {$urandom, $urandom};
      wb_result  = {$urandom, $urandom};
      ctrl_aluop = 2'($urandom);
      funct3     = 3'($urandom);
      funct7_5   = $urandom_range(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
